// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              StallF,
  output logic              StallM
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_eff;
  logic             d_eff;
  logic             starved;
  logic             grant_i;
  logic             grant_d;
  logic             i_done;
  logic             d_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // A requester in its ready cycle is masked so it cannot be re-granted on the completion it is consuming.
  assign i_eff   = i_req & ~i_ready;
  assign d_eff   = d_req & ~d_ready;
  assign starved = (starve_cnt == CNT_MAX);
  assign i_done  = (state == I_BUSY) && m_ack;
  assign d_done  = (state == D_BUSY) && m_ack;

  assign m_req  = (state != IDLE);
  assign StallF = i_req & ~i_ready;
  assign StallM = d_req & ~d_ready;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_eff && !(i_eff && starved)) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (i_eff) begin
          grant_i   = 1'b1;
          state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      state   <= state_nxt;
      i_ready <= i_done;
      d_ready <= d_done;
      if (grant_d) begin
        starve_cnt <= i_eff ? sat_inc(starve_cnt) : '0;
      end else if (grant_i) begin
        starve_cnt <= '0;
      end
    end
  end

  // Memory-side command registers stay frozen for the whole busy period; fetch grants leave m_wdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (grant_d) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_we   <= 1'b0;
        m_addr <= i_addr;
      end
      if (i_done) i_rdata <= m_rdata;
      if (d_done && !m_we) d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus a starvation sequence.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        StallF;
  logic        StallM;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .StallF(StallF), .StallM(StallM)
  );

  typedef struct {
    logic [31:0] rst, ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack;
    logic [31:0] mreq, mwe, maddr, mwdata, irdy, drdy, irdata, drdata, stf, stm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then move to the falling edge for sampling.
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
                     input logic ma);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dd; m_rdata = mr; m_ack = ma;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
    repeat (2) @(posedge clk);

    // rst ireq iaddr dreq dwe daddr dwdata mrdata mack | mreq mwe maddr mwdata irdy drdy irdata drdata stf stm
    tbl.push_back('{0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0,0,0});
    // single zero-wait load
    tbl.push_back('{0,0,0,1,0,'h40,0,0,0,          0,0,0,0,0,0,0,0,0,1});
    tbl.push_back('{0,0,0,1,0,'h40,0,32'hDEADBEEF,1, 1,0,'h40,0,0,0,0,0,0,1});
    tbl.push_back('{0,0,0,1,0,'h40,0,0,0,          0,0,'h40,0,0,1,0,32'hDEADBEEF,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,             0,0,'h40,0,0,0,0,32'hDEADBEEF,0,0});
    // store with three wait cycles, inputs disturbed while busy
    tbl.push_back('{0,0,0,1,1,'h80,'h12345678,0,0, 0,0,'h40,0,0,0,0,32'hDEADBEEF,0,1});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{0,0,0,1,1,'h999,'hAAAA,'h55555555,0, 1,1,'h80,'h12345678,0,0,0,32'hDEADBEEF,0,1});
    tbl.push_back('{0,0,0,1,1,'h999,'hAAAA,'h77777777,1,   1,1,'h80,'h12345678,0,0,0,32'hDEADBEEF,0,1});
    tbl.push_back('{0,0,0,1,1,'h80,'h12345678,0,0, 0,1,'h80,'h12345678,0,1,0,32'hDEADBEEF,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,             0,1,'h80,'h12345678,0,0,0,32'hDEADBEEF,0,0});
    // simultaneous fetch and load: data first, fetch granted in the data ready cycle
    tbl.push_back('{0,1,'h200,1,0,'h44,0,0,0,          0,1,'h80,'h12345678,0,0,0,32'hDEADBEEF,1,1});
    tbl.push_back('{0,1,'h200,1,0,'h44,0,'h11111111,1, 1,0,'h44,0,0,0,0,32'hDEADBEEF,1,1});
    tbl.push_back('{0,1,'h200,1,0,'h44,0,0,0,          0,0,'h44,0,0,1,0,'h11111111,1,0});
    tbl.push_back('{0,1,'h200,0,0,0,0,'h22222222,1,    1,0,'h200,0,0,0,0,'h11111111,1,0});
    tbl.push_back('{0,1,'h200,0,0,0,0,0,0,             0,0,'h200,0,1,0,'h22222222,'h11111111,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,                 0,0,'h200,0,0,0,'h22222222,'h11111111,0,0});
    // stray ack while idle, then fetch
    tbl.push_back('{0,0,0,0,0,0,0,'hBAD,1,             0,0,'h200,0,0,0,'h22222222,'h11111111,0,0});
    tbl.push_back('{0,1,'h100,0,0,0,0,0,0,             0,0,'h200,0,0,0,'h22222222,'h11111111,1,0});
    tbl.push_back('{0,1,'h100,0,0,0,0,'h13,1,          1,0,'h100,0,0,0,'h22222222,'h11111111,1,0});
    tbl.push_back('{0,1,'h100,0,0,0,0,0,0,             0,0,'h100,0,1,0,'h13,'h11111111,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,                 0,0,'h100,0,0,0,'h13,'h11111111,0,0});
    // reset while a load is stalled, then a late ack in idle
    tbl.push_back('{0,0,0,1,0,'h300,'h5A5A,0,0,        0,0,'h100,0,0,0,'h13,'h11111111,0,1});
    tbl.push_back('{1,0,0,1,0,'h300,'h5A5A,0,0,        1,0,'h300,'h5A5A,0,0,'h13,'h11111111,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,'h99,1,              0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,0,0,0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst[0]; i_req = tbl[i].ireq[0]; i_addr = tbl[i].iaddr;
      d_req = tbl[i].dreq[0]; d_we = tbl[i].dwe[0]; d_addr = tbl[i].daddr;
      d_wdata = tbl[i].dwdata; m_rdata = tbl[i].mrdata; m_ack = tbl[i].mack[0];
      @(negedge clk);
      chk($sformatf("v%0d_m_req", i),   {31'b0, m_req},   tbl[i].mreq);
      chk($sformatf("v%0d_m_we", i),    {31'b0, m_we},    tbl[i].mwe);
      chk($sformatf("v%0d_m_addr", i),  m_addr,           tbl[i].maddr);
      chk($sformatf("v%0d_m_wdata", i), m_wdata,          tbl[i].mwdata);
      chk($sformatf("v%0d_i_ready", i), {31'b0, i_ready}, tbl[i].irdy);
      chk($sformatf("v%0d_d_ready", i), {31'b0, d_ready}, tbl[i].drdy);
      chk($sformatf("v%0d_i_rdata", i), i_rdata,          tbl[i].irdata);
      chk($sformatf("v%0d_d_rdata", i), d_rdata,          tbl[i].drdata);
      chk($sformatf("v%0d_StallF", i),  {31'b0, StallF},  tbl[i].stf);
      chk($sformatf("v%0d_StallM", i),  {31'b0, StallM},  tbl[i].stm);
    end

    // Starvation: fetch pending at every arbitration point; i_req dips only in data ready cycles
    // so each decision sees both requesters effective. Four data grants, then the fetch must win.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 'h500, 1, 0, 'h600 + k, 0, 0, 0);
      chk($sformatf("starve%0d_idle", k), {31'b0, m_req}, 32'd0);
      cyc(1, 'h500, 1, 0, 'h600 + k, 0, 'hC0 + k, 1);
      chk($sformatf("starve%0d_m_addr", k), m_addr, 'h600 + k);
      cyc(0, 'h500, 1, 0, 'h600 + k, 0, 0, 0);
      chk($sformatf("starve%0d_d_ready", k), {31'b0, d_ready}, 32'd1);
      chk($sformatf("starve%0d_d_rdata", k), d_rdata, 'hC0 + k);
    end
    cyc(1, 'h500, 1, 0, 'h700, 0, 0, 0);
    cyc(1, 'h500, 1, 0, 'h700, 0, 'hF00D, 1);
    chk("starve_fetch_m_addr", m_addr, 'h500);
    chk("starve_fetch_m_we", {31'b0, m_we}, 32'd0);
    cyc(1, 'h500, 1, 0, 'h700, 0, 0, 0);
    chk("starve_fetch_i_ready", {31'b0, i_ready}, 32'd1);
    chk("starve_fetch_i_rdata", i_rdata, 'hF00D);
    cyc(0, 0, 1, 0, 'h700, 0, 'hC5, 1);
    chk("resume_m_req", {31'b0, m_req}, 32'd1);
    chk("resume_m_addr", m_addr, 'h700);
    cyc(0, 0, 1, 0, 'h700, 0, 0, 0);
    chk("resume_d_ready", {31'b0, d_ready}, 32'd1);
    chk("resume_d_rdata", d_rdata, 'hC5);
    // Counter cleared: with both requesting again, data still wins.
    cyc(1, 'h500, 1, 0, 'h800, 0, 0, 0);
    cyc(1, 'h500, 1, 0, 'h800, 0, 'hC6, 1);
    chk("cleared_m_addr", m_addr, 'h800);
    cyc(1, 'h500, 1, 0, 'h800, 0, 0, 0);
    chk("cleared_d_ready", {31'b0, d_ready}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
